// File: rtl/display_pkg.sv
// Shared encodings for the display source sequencer: mode constants,
// FSM state type and a constant-foldable ceiling-log2 helper.
package display_pkg;

    localparam logic MODE_PRIORITY = 1'b0;
    localparam logic MODE_ROTATE   = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/next_valid_finder.sv
// Combinational search for the first valid channel strictly after start,
// wrapping modulo NUM_CH; start itself is the last candidate checked.
module next_valid_finder
    import display_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [IDX_W-1:0]  start,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [IDX_W-1:0] cand [NUM_CH];

    // cand[gi] is (start + gi + 1) mod NUM_CH, without a divider
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, start} + (IDX_W+1)'(gi + 1);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_CH))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_CH))
                            : sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        idx = start;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                idx = cand[k];
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/display_source_sequencer.sv
// Selects which channel word drives the seven-segment display, either by
// fixed priority or by timed rotation over the valid channels.
module display_source_sequencer
    import display_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 16,
    parameter int DWELL_CYCLES = 40_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic                       mode,
    input  logic                       hold,
    input  logic [DATA_W-1:0]          idle_code,
    output logic [DATA_W-1:0]          disp_out,
    output logic [clog2(NUM_CH)-1:0]   disp_ch,
    output logic                       disp_idle,
    output logic                       switch_pulse
);

    localparam int IDX_W = clog2(NUM_CH);
    localparam int CNT_W = clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LOW_START = IDX_W'(NUM_CH - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   sel_reg, sel_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mode_reg;
    logic               mode_changed;

    logic [IDX_W-1:0]   low_idx, next_idx;
    logic               any_low, any_next, any_valid;

    logic [DATA_W-1:0]  disp_out_next;
    logic [IDX_W-1:0]   disp_ch_next;
    logic               disp_idle_next;
    logic               switch_next;

    logic [DATA_W-1:0]  ch_word [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_word[gi] = ch_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Starting the search at the top index makes the wrap land on channel 0 first
    next_valid_finder #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_low (
        .valid (ch_valid),
        .start (LOW_START),
        .idx   (low_idx),
        .any   (any_low)
    );

    next_valid_finder #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_next (
        .valid (ch_valid),
        .start (sel_reg),
        .idx   (next_idx),
        .any   (any_next)
    );

    assign any_valid    = any_low | any_next;
    assign mode_changed = (mode != mode_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            mode_reg  <= MODE_PRIORITY;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (any_valid) begin
                    state_next = ST_SHOW;
                    sel_next   = low_idx;
                end
            end
            ST_SHOW: begin
                if (!any_valid) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (mode == MODE_PRIORITY) begin
                    cnt_next = '0;
                    if (!hold || !ch_valid[sel_reg] || mode_changed) begin
                        sel_next = low_idx;
                    end
                end else if (!ch_valid[sel_reg]) begin
                    // Lost source: move on at once, even under hold
                    sel_next = next_idx;
                    cnt_next = '0;
                end else if (mode_changed) begin
                    cnt_next = '0;
                end else if (!hold) begin
                    if (cnt_reg == CNT_TERM) begin
                        cnt_next = '0;
                        sel_next = next_idx;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        disp_idle_next = (state_next == ST_IDLE);
        disp_ch_next   = sel_next;
        disp_out_next  = disp_idle_next ? idle_code : ch_word[sel_next];
        switch_next    = (disp_ch_next != disp_ch) || (disp_idle_next != disp_idle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_out     <= '0;
            disp_ch      <= '0;
            disp_idle    <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            disp_out     <= disp_out_next;
            disp_ch      <= disp_ch_next;
            disp_idle    <= disp_idle_next;
            switch_pulse <= switch_next;
        end
    end

endmodule

// File: doc/display_source_sequencer.md
DISPLAY_SOURCE_SEQUENCER -- requirements
Module: display_source_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of display source channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 16, width of each channel word and the display output.
REQ-003 SHALL have parameter DWELL_CYCLES, default 40_000_000, clocks per channel in rotate mode (1 s at 40 MHz), minimum 2.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port ch_data, input, NUM_CH*DATA_W, channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port ch_valid, input, NUM_CH, per-channel "has content" flags.
REQ-008 SHALL have port mode, input, 1; 0 = priority, 1 = rotate.
REQ-009 SHALL have port hold, input, 1, freezes channel selection and dwell count.
REQ-010 SHALL have port idle_code, input, DATA_W, word shown when no channel is valid.
REQ-011 SHALL have port disp_out, output, DATA_W, registered word to the seven-segment driver.
REQ-012 SHALL have port disp_ch, output, clog2(NUM_CH), index of the channel shown.
REQ-013 SHALL have port disp_idle, output, 1, high while idle_code is shown.
REQ-014 SHALL have port switch_pulse, output, 1, one-cycle strobe on any change of displayed source.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no valid channel) and SHOW (channel sel displayed).
REQ-016 SHALL register all outputs, with one-clock latency from inputs to disp_out, disp_ch and disp_idle.
REQ-017 In IDLE, SHALL drive disp_out = idle_code, disp_idle = 1, and hold disp_ch at its last value.
REQ-018 From IDLE with any ch_valid set, SHALL enter SHOW with sel = lowest-index valid channel, in either mode.
REQ-019 In SHOW, SHALL drive disp_out = live ch_data[sel] every cycle; data tracks source updates without a switch.
REQ-020 In SHOW, SHALL enter IDLE in the next cycle when ch_valid is all zero; hold does not prevent this.
REQ-021 Priority mode: SHALL set sel each cycle to the lowest-index valid channel; dwell counter held at 0.
REQ-022 Rotate mode: dwell counter SHALL increment each unheld cycle in SHOW and, at DWELL_CYCLES-1, reset to 0 and advance sel to the next valid index above sel, wrapping modulo NUM_CH.
REQ-023 Rotate mode: SHALL keep sel and reset the counter when sel is the only valid channel at terminal count; no switch_pulse in that case.
REQ-024 Rotate mode: SHALL advance immediately to the next valid index (wrapping) and reset the counter when ch_valid[sel] drops while others remain valid.
REQ-025 hold = 1: SHALL freeze the counter and sel, except when ch_valid[sel] = 0, where REQ-020/REQ-024 apply and override hold.
REQ-026 Priority mode with hold = 1: SHALL keep sel even if a lower-index channel becomes valid.
REQ-027 A mode change SHALL reset the dwell counter to 0; entering priority mode re-evaluates sel the same cycle.
REQ-028 switch_pulse SHALL be 1 for exactly the cycle in which disp_ch or disp_idle changes value, and 0 otherwise.
REQ-029 The counter width SHALL be clog2(DWELL_CYCLES) and the counter SHALL never exceed DWELL_CYCLES-1.

Reset
REQ-030 While reset is high, SHALL force the IDLE state, sel = 0, counter = 0, disp_out = 0, disp_ch = 0, disp_idle = 1 and switch_pulse = 0.
REQ-031 After reset deasserts, the first outputs SHALL follow REQ-017/REQ-018 on the next clk edge; reset mid-rotation discards dwell progress.

Structure
REQ-032 Shared package display_pkg SHALL hold the mode encoding constants (MODE_PRIORITY = 0, MODE_ROTATE = 1), the FSM state encoding and a clog2 function.
REQ-033 SHALL instantiate one combinational sub-module, next_valid_finder, which returns the next valid index above a start index with wrap, plus an any-valid flag; the same sub-module serves lowest-valid search with start = NUM_CH-1.

Verification (NUM_CH=4, DATA_W=16, DWELL_CYCLES=4)
REQ-034 Reset release with ch_valid=0000 and idle_code=16'hEEEE -> disp_out=EEEE, disp_idle=1, no switch_pulse.
REQ-035 Priority: ch_valid=0110, ch1=0x1234 -> disp_ch=1 and disp_out=1234 one cycle later; set bit0 (ch0=0xAAAA) -> disp_ch=0, single switch_pulse.
REQ-036 Rotate: ch_valid=1011 -> disp_ch sequence 0,1,3,0, each held exactly 4 cycles, with a switch_pulse at each change.
REQ-037 Rotate: clear ch_valid[sel]=3 mid-dwell -> next cycle disp_ch=0 and the counter restarts, giving a full 4-cycle dwell.
REQ-038 Rotate with hold=1 for 10 cycles on ch1 -> disp_ch stays 1 with no pulse; clear all valid during hold -> IDLE next cycle and disp_out=idle_code.
REQ-039 Assert reset mid-dwell on ch3 -> outputs at reset values immediately; after release, lowest valid channel shown next cycle.
